// File: rtl/idex_skid_stage.sv
// ID/EX pipeline register with a two-entry skid buffer: oReady is a registered
// function of skid occupancy, so there is no combinational path from iReady.
module idex_skid_stage #(
  parameter int DATA_W  = 32,
  parameter int FUN_W   = 6,
  parameter int RADDR_W = 5,
  parameter int CTRL_W  = 12,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               iValid,
  output logic               oReady,
  input  logic [CTRL_W-1:0]  iCtrl,
  input  logic [DATA_W-1:0]  iRegOut1,
  input  logic [DATA_W-1:0]  iRegOut2,
  input  logic [FUN_W-1:0]   iFun,
  input  logic [RADDR_W-1:0] iDstReg,
  input  logic               iFlush,
  output logic               oValid,
  input  logic               iReady,
  output logic [CTRL_W-1:0]  oCtrl,
  output logic [DATA_W-1:0]  oRegOut1,
  output logic [DATA_W-1:0]  oRegOut2,
  output logic [FUN_W-1:0]   oFun,
  output logic [RADDR_W-1:0] oDstReg,
  output logic [CNT_W-1:0]   oBubbleCnt
);

  localparam int PAY_W = CTRL_W + 2*DATA_W + FUN_W + RADDR_W;

  logic [PAY_W-1:0]  main_q, main_d, skid_q, skid_d, in_pay;
  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0]  bub_q, bub_d;
  logic [CTRL_W-1:0] main_ctrl;
  logic              accept, issue;

  assign in_pay = {iCtrl, iRegOut1, iRegOut2, iFun, iDstReg};
  assign accept = iValid & ~skid_valid_q;
  assign issue  = main_valid_q & iReady;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    bub_d        = bub_q;

    if (!main_valid_q || issue) begin
      // skid_valid implies oReady=0, so no input can be accepted alongside a skid drain
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        if (accept) main_d = in_pay;
        main_valid_d = accept;
      end
    end else if (accept) begin
      skid_d       = in_pay;
      skid_valid_d = 1'b1;
    end

    // EX has already captured the issuing entry; everything behind it is dropped
    if (iFlush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end

    if (!main_valid_q && iReady && (bub_q != {CNT_W{1'b1}}))
      bub_d = bub_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      bub_q        <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      bub_q        <= bub_d;
    end
  end

  assign {main_ctrl, oRegOut1, oRegOut2, oFun, oDstReg} = main_q;
  assign oCtrl      = main_valid_q ? main_ctrl : '0;
  assign oValid     = main_valid_q;
  assign oReady     = ~skid_valid_q;
  assign oBubbleCnt = bub_q;

endmodule

// File: tb/tb_idex_skid_stage.sv
// Scoreboard bench for idex_skid_stage: the reference model is a FIFO of held
// instructions (ready = fewer than two held, valid = at least one held).
module tb_idex_skid_stage;

  typedef struct {
    logic [11:0] c;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  f;
    logic [4:0]  d;
  } item_t;

  logic        clk = 1'b1;
  logic        rst_n, iValid, iFlush, iReady;
  logic [11:0] iCtrl;
  logic [31:0] iRegOut1, iRegOut2;
  logic [5:0]  iFun;
  logic [4:0]  iDstReg;
  logic        oReady, oValid;
  logic [11:0] oCtrl;
  logic [31:0] oRegOut1, oRegOut2;
  logic [5:0]  oFun;
  logic [4:0]  oDstReg;
  logic [15:0] oBubbleCnt;

  logic        oReady2, oValid2;
  logic [11:0] oCtrl2;
  logic [31:0] oRegOut1_2, oRegOut2_2;
  logic [5:0]  oFun2;
  logic [4:0]  oDstReg2;
  logic [1:0]  oBubbleCnt2;

  int    n_tests = 0;
  int    n_fail  = 0;
  bit    mon_en  = 0;
  item_t sb[$];
  int    bub_m   = 0;
  int    bub2_m  = 0;

  always #5 clk = ~clk;

  idex_skid_stage dut (
    .clk(clk), .rst_n(rst_n), .iValid(iValid), .oReady(oReady), .iCtrl(iCtrl),
    .iRegOut1(iRegOut1), .iRegOut2(iRegOut2), .iFun(iFun), .iDstReg(iDstReg),
    .iFlush(iFlush), .oValid(oValid), .iReady(iReady), .oCtrl(oCtrl),
    .oRegOut1(oRegOut1), .oRegOut2(oRegOut2), .oFun(oFun), .oDstReg(oDstReg),
    .oBubbleCnt(oBubbleCnt));

  idex_skid_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .iValid(iValid), .oReady(oReady2), .iCtrl(iCtrl),
    .iRegOut1(iRegOut1), .iRegOut2(iRegOut2), .iFun(iFun), .iDstReg(iDstReg),
    .iFlush(iFlush), .oValid(oValid2), .iReady(iReady), .oCtrl(oCtrl2),
    .oRegOut1(oRegOut1_2), .oRegOut2(oRegOut2_2), .oFun(oFun2), .oDstReg(oDstReg2),
    .oBubbleCnt(oBubbleCnt2));

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares what the DUT presents against the model, pops on issue
  always @(negedge clk) begin
    if (mon_en) begin
      item_t e;
      bit    exp_valid;
      exp_valid = (sb.size() > 0);
      check("oValid", {95'd0, oValid}, {95'd0, exp_valid});
      check("oReady", {95'd0, oReady}, {95'd0, sb.size() < 2});
      check("oBubbleCnt", {80'd0, oBubbleCnt}, 96'(bub_m));
      check("oBubbleCnt_w2", {94'd0, oBubbleCnt2}, 96'(bub2_m));
      if (exp_valid) begin
        e = sb[0];
        check("payload", {oCtrl, oRegOut1, oRegOut2, oFun, oDstReg, 9'd0},
              {e.c, e.a, e.b, e.f, e.d, 9'd0});
        if (iReady && rst_n) void'(sb.pop_front());
      end else begin
        check("oCtrl_bubble", {84'd0, oCtrl}, 96'd0);
      end
      if (!rst_n) begin
        bub_m  = 0;
        bub2_m = 0;
      end else if (!exp_valid && iReady) begin
        if (bub_m < 65535) bub_m++;
        if (bub2_m < 3) bub2_m++;
      end
    end
  end

  function automatic item_t rand_item(input logic [4:0] d);
    item_t it;
    it.c = 12'($urandom);
    if (it.c == 12'd0) it.c = 12'h801;
    it.a = $urandom;
    it.b = $urandom;
    it.f = 6'($urandom);
    it.d = d;
    return it;
  endfunction

  // One cycle: drive, let the monitor see it, then record accept/flush/reset
  task automatic step(input bit v, input bit r, input bit fl, input bit rs, input item_t it);
    bit acc;
    rst_n    = ~rs;
    iValid   = v;
    iReady   = r;
    iFlush   = fl;
    iCtrl    = it.c;
    iRegOut1 = it.a;
    iRegOut2 = it.b;
    iFun     = it.f;
    iDstReg  = it.d;
    acc = v && (sb.size() < 2);
    @(negedge clk);
    #1;
    if (rs || fl) sb.delete();
    else if (acc) sb.push_back(it);
    @(posedge clk);
    #1;
  endtask

  initial begin
    item_t x;
    rst_n = 0; iValid = 0; iReady = 0; iFlush = 0;
    iCtrl = '0; iRegOut1 = '0; iRegOut2 = '0; iFun = '0; iDstReg = '0;
    #1;
    x = rand_item(5'd0);
    step(0, 1, 0, 1, x);
    mon_en = 1;
    check("reset_oValid", {95'd0, oValid}, 96'd0);
    check("reset_oReady", {95'd0, oReady}, 96'd1);

    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, x);
    check("bubble_5", {80'd0, oBubbleCnt}, 96'd5);
    check("bubble_w2_sat", {94'd0, oBubbleCnt2}, 96'd3);
    step(0, 1, 0, 0, x);

    for (int i = 1; i <= 8; i++) step(1, 1, 0, 0, rand_item(5'(i)));
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, x);

    step(1, 0, 0, 0, rand_item(5'd10));
    step(1, 0, 0, 0, rand_item(5'd11));
    check("bp_ready_low", {95'd0, oReady}, 96'd0);
    check("bp_hold_A", {91'd0, oDstReg}, 96'd10);
    step(0, 1, 0, 0, x);
    step(0, 1, 0, 0, x);
    step(0, 1, 0, 0, x);

    step(1, 0, 0, 0, rand_item(5'd20));
    step(1, 0, 0, 0, rand_item(5'd21));
    step(1, 0, 1, 0, rand_item(5'd22));
    check("flush_valid", {95'd0, oValid}, 96'd0);
    check("flush_ctrl", {84'd0, oCtrl}, 96'd0);
    check("flush_ready", {95'd0, oReady}, 96'd1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, x);

    step(1, 0, 0, 0, rand_item(5'd25));
    step(1, 0, 0, 0, rand_item(5'd26));
    step(1, 1, 1, 1, rand_item(5'd27));
    check("rst_outputs", {oCtrl, oRegOut1, oRegOut2, oFun, oDstReg, oValid, 8'd0}, 96'd0);
    check("rst_ready", {95'd0, oReady}, 96'd1);
    check("rst_bubble", {80'd0, oBubbleCnt}, 96'd0);

    for (int i = 0; i < 3000; i++)
      step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 40) == 0,
           ($urandom % 150) == 0, rand_item(5'($urandom)));
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, x);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
